// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// The transmitter's busy line is active-low, so both levels are named here.
package uart_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WAIT_START,
      WAIT_DONE,
      NEXT
   } sched_state_t;

   localparam logic UART_NOT_BUSY = 1'b1;
   localparam logic UART_BUSY     = 1'b0;

   localparam logic [15:0] DEFAULT_PRESCALER_VAL = 16'd5208;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after 'pointer',
// wrapping modulo N; one-hot grant plus its binary index.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] pointer,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] index
);

   localparam logic [IW:0] NUM = (IW + 1)'(N);

   logic [IW:0]   cand;
   logic [IW-1:0] cand_idx;
   logic          found;

   always_comb begin
      grant    = '0;
      index    = '0;
      found    = 1'b0;
      cand     = '0;
      cand_idx = '0;
      for (int off = 0; off < N; off++) begin
         cand = {1'b0, pointer} + (IW + 1)'(off);
         if (cand >= NUM) begin
            cand = cand - NUM;
         end
         cand_idx = cand[IW-1:0];
         if (!found && req[cand_idx]) begin
            found           = 1'b1;
            grant[cand_idx] = 1'b1;
            index           = cand_idx;
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin, packet-locked sharing of one 8N1 UART transmitter among NUM_REQ requesters.
// Optional watchdog on the transmitter handshake: define UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_scheduler
   import uart_sched_pkg::*;
#(
   parameter int          NUM_REQ           = 4,
   parameter logic [15:0] DEFAULT_PRESCALER = DEFAULT_PRESCALER_VAL,
   parameter logic [31:0] TIMEOUT_CYCLES    = 32'd2000000
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [NUM_REQ-1:0]   grant,
   input  logic [15:0]          cfg_prescaler,
   input  logic                 cfg_update,
   input  logic                 uart_busy,
   output logic [7:0]           uart_data,
   output logic                 uart_transmit,
   output logic [15:0]          prescaler,
   output logic                 sched_idle
`ifdef UART_TX_SCHED_TIMEOUT_EN
   ,
   output logic                 sched_timeout
`endif
);

   localparam int IW = $clog2(NUM_REQ);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

   sched_state_t       state, state_next;
   logic [IW-1:0]      idx, idx_next;
   logic [IW-1:0]      ptr, ptr_next;
   logic [IW-1:0]      ptr_after_owner;
   logic [NUM_REQ-1:0] grant_next, ready_next;
   logic [NUM_REQ-1:0] arb_grant;
   logic [IW-1:0]      arb_index;
   logic [7:0]         data_next;
   logic               transmit_next;
   logic [15:0]        prescaler_next;
   logic               pend, pend_next;
   logic [15:0]        pend_val, pend_val_next;
   logic               last_flag, last_next;
   logic               in_wait;

`ifdef UART_TX_SCHED_TIMEOUT_EN
   logic [31:0] wd_count, wd_next;
   logic        timeout_next;
`endif

   rr_arbiter #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_arb (
      .req     (req_valid),
      .pointer (ptr),
      .grant   (arb_grant),
      .index   (arb_index)
   );

   assign ptr_after_owner = (idx == LAST_IDX) ? '0 : idx + 1'b1;
   assign in_wait         = (state == WAIT_START) || (state == WAIT_DONE);
   assign sched_idle      = (state == IDLE) && !pend;

   // A pending baud change always wins over arbitration so the link never
   // starts a frame with a stale prescaler.
   always_comb begin
      state_next     = state;
      idx_next       = idx;
      ptr_next       = ptr;
      grant_next     = grant;
      ready_next     = '0;
      data_next      = uart_data;
      transmit_next  = uart_transmit;
      prescaler_next = prescaler;
      pend_next      = pend;
      pend_val_next  = pend_val;
      last_next      = last_flag;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      timeout_next   = 1'b0;
      wd_next        = '0;
`endif

      case (state)
         IDLE: begin
            if (pend) begin
               prescaler_next = pend_val;
               pend_next      = 1'b0;
            end else if (|req_valid) begin
               grant_next = arb_grant;
               idx_next   = arb_index;
               state_next = LOAD;
            end
         end
         LOAD: begin
            data_next     = req_data[{idx, 3'b000} +: 8];
            last_next     = req_last[idx];
            transmit_next = 1'b0;
            state_next    = WAIT_START;
         end
         WAIT_START: begin
            // Raising transmit as soon as busy shows keeps the transmitter from chaining a second frame.
            if (uart_busy == UART_BUSY) begin
               transmit_next   = 1'b1;
               ready_next[idx] = 1'b1;
               state_next      = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (uart_busy == UART_NOT_BUSY) begin
               if (last_flag) begin
                  ptr_next   = ptr_after_owner;
                  grant_next = '0;
                  state_next = IDLE;
               end else begin
                  state_next = NEXT;
               end
            end
         end
         NEXT: begin
            if (req_valid[idx]) begin
               state_next = LOAD;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      if (cfg_update) begin
         pend_next     = 1'b1;
         pend_val_next = cfg_prescaler;
      end

`ifdef UART_TX_SCHED_TIMEOUT_EN
      if (in_wait && (wd_count == TIMEOUT_CYCLES - 32'd1)) begin
         transmit_next = 1'b1;
         grant_next    = '0;
         ready_next    = '0;
         ptr_next      = ptr_after_owner;
         state_next    = IDLE;
         timeout_next  = 1'b1;
      end
      if (in_wait && (state_next == state)) begin
         wd_next = wd_count + 32'd1;
      end
`endif
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state         <= IDLE;
         idx           <= '0;
         ptr           <= '0;
         grant         <= '0;
         req_ready     <= '0;
         uart_data     <= '0;
         uart_transmit <= 1'b1;
         prescaler     <= DEFAULT_PRESCALER;
         pend          <= 1'b0;
         pend_val      <= '0;
         last_flag     <= 1'b0;
      end else begin
         state         <= state_next;
         idx           <= idx_next;
         ptr           <= ptr_next;
         grant         <= grant_next;
         req_ready     <= ready_next;
         uart_data     <= data_next;
         uart_transmit <= transmit_next;
         prescaler     <= prescaler_next;
         pend          <= pend_next;
         pend_val      <= pend_val_next;
         last_flag     <= last_next;
      end
   end

`ifdef UART_TX_SCHED_TIMEOUT_EN
   always_ff @(posedge clock) begin
      if (!reset) begin
         wd_count      <= '0;
         sched_timeout <= 1'b0;
      end else begin
         wd_count      <= wd_next;
         sched_timeout <= timeout_next;
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: a bit-level transmitter model plus a
// scoreboard of expected (requester, byte) frames; timeout checks need UART_TX_SCHED_TIMEOUT_EN.
module tb_uart_tx_scheduler;

   localparam int NR = 4;

   typedef logic [8:0] item_t;
   typedef struct packed {
      logic [1:0] req;
      logic [7:0] data;
   } exp_t;

   logic              clock;
   logic              reset;
   logic [NR-1:0]     req_valid;
   logic [8*NR-1:0]   req_data;
   logic [NR-1:0]     req_last;
   logic [NR-1:0]     req_ready;
   logic [NR-1:0]     grant;
   logic [15:0]       cfg_prescaler;
   logic              cfg_update;
   logic              uart_busy;
   logic [7:0]        uart_data;
   logic              uart_transmit;
   logic [15:0]       prescaler;
   logic              sched_idle;
`ifdef UART_TX_SCHED_TIMEOUT_EN
   logic              sched_timeout;
`endif

   int    total = 0;
   int    bad   = 0;
   item_t txq[NR][$];
   exp_t  sb[$];
   int    ready_cnt[NR];

   logic       model_busy = 1'b1;
   logic       tx_line    = 1'b1;
   logic       active     = 1'b0;
   logic       force_idle = 1'b0;
   logic       saw_high   = 1'b0;
   logic       tk;
   logic [9:0] frame;
   logic [9:0] line_bits;
   logic [9:0] last_line;
   logic [3:0] cap_gnt;
   int         tick_cnt  = 0;
   int         bitn      = 0;
   int         cyc       = 0;
   int         start_len = 0;

   assign uart_busy = force_idle ? 1'b1 : model_busy;

   uart_tx_scheduler #(
      .NUM_REQ           (NR),
      .DEFAULT_PRESCALER (16'd5208)
`ifdef UART_TX_SCHED_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES    (32'd100)
`endif
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_last      (req_last),
      .req_ready     (req_ready),
      .grant         (grant),
      .cfg_prescaler (cfg_prescaler),
      .cfg_update    (cfg_update),
      .uart_busy     (uart_busy),
      .uart_data     (uart_data),
      .uart_transmit (uart_transmit),
      .prescaler     (prescaler),
      .sched_idle    (sched_idle)
`ifdef UART_TX_SCHED_TIMEOUT_EN
      ,
      .sched_timeout (sched_timeout)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   function automatic logic [1:0] onehotIndex(input logic [3:0] oh);
      for (int i = 0; i < NR; i++) begin
         if (oh[i]) return 2'(i);
      end
      return 2'd0;
   endfunction

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic applyStimulus(input int id, input logic [7:0] data, input logic last, input bit expect_frame);
      txq[id].push_back({last, data});
      if (expect_frame) sb.push_back('{req: 2'(id), data: data});
   endtask

   task automatic clearCounts();
      for (int i = 0; i < NR; i++) ready_cnt[i] = 0;
   endtask

   function automatic bit allDone();
      bit ok;
      ok = sched_idle && !active && (grant == '0);
      for (int i = 0; i < NR; i++) begin
         if (txq[i].size() != 0) ok = 1'b0;
      end
      return ok;
   endfunction

   task automatic waitIdle(input string tag);
      int n;
      n = 0;
      while (!allDone() && n < 5000) begin
         tick();
         n++;
      end
      checkOutput(tag, 32'(allDone()), 1);
   endtask

   task automatic frameDone();
      exp_t e;
      if (sb.size() == 0) begin
         checkOutput("sb_empty", 0, 1);
      end else begin
         e = sb.pop_front();
         checkOutput("frame_req", 32'(onehotIndex(cap_gnt)), 32'(e.req));
         checkOutput("frame_byte", 32'(frame[8:1]), 32'(e.data));
      end
   endtask

   // Transmitter model: bit period of 'prescaler' clocks, starts only on a tick with transmit low.
   always @(negedge clock) begin
      tk = 1'b0;
      if (tick_cnt >= int'(prescaler) - 1) begin
         tk       = 1'b1;
         tick_cnt = 0;
      end else begin
         tick_cnt++;
      end
      if (!active && uart_transmit === 1'b1) saw_high = 1'b1;
      if (tk) begin
         if (!active) begin
            if (uart_transmit === 1'b0 && !force_idle) begin
               active     = 1'b1;
               frame      = {1'b1, uart_data, 1'b0};
               bitn       = 0;
               cyc        = 0;
               tx_line    = 1'b0;
               model_busy = 1'b0;
               cap_gnt    = grant;
               checkOutput("gap_high", 32'(saw_high), 1);
               saw_high   = 1'b0;
            end
         end else begin
            if (bitn == 0) start_len = cyc + 1;
            line_bits[bitn] = tx_line;
            bitn++;
            cyc = 0;
            if (bitn == 10) begin
               active     = 1'b0;
               model_busy = 1'b1;
               tx_line    = 1'b1;
               last_line  = line_bits;
               frameDone();
            end else begin
               tx_line = frame[bitn];
            end
         end
      end else if (active) begin
         cyc++;
      end
   end

   // Requester side: present each queue head, retire it on its req_ready pulse.
   initial begin
      item_t h;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      forever begin
         @(posedge clock);
         #1;
         for (int i = 0; i < NR; i++) begin
            if (req_ready[i] === 1'b1) begin
               ready_cnt[i]++;
               if (txq[i].size() > 0) void'(txq[i].pop_front());
            end
         end
         for (int i = 0; i < NR; i++) begin
            if (txq[i].size() > 0) begin
               h               = txq[i][0];
               req_valid[i]    = 1'b1;
               req_data[i*8 +: 8] = h[7:0];
               req_last[i]     = h[8];
            end else begin
               req_valid[i] = 1'b0;
               req_last[i]  = 1'b0;
            end
         end
      end
   end

   initial begin
      #800000;
      $display("[TB] FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] simulation did not complete");
   end

   initial begin
      int n;
      logic [7:0] b;
      reset         = 1'b0;
      cfg_update    = 1'b0;
      cfg_prescaler = '0;
      clearCounts();
      repeat (3) tick();
      checkOutput("rst_grant", 32'(grant), 0);
      checkOutput("rst_ready", 32'(req_ready), 0);
      checkOutput("rst_data", 32'(uart_data), 0);
      checkOutput("rst_tx", 32'(uart_transmit), 1);
      checkOutput("rst_psc", 32'(prescaler), 5208);
      checkOutput("rst_idle", 32'(sched_idle), 1);
      reset = 1'b1;
      tick();

      $display("[TB] set prescaler to 4 while idle");
      cfg_prescaler = 16'd4;
      cfg_update    = 1'b1;
      tick();
      cfg_update = 1'b0;
      checkOutput("cfg_pending", 32'(sched_idle), 0);
      tick();
      checkOutput("cfg_apply", 32'(prescaler), 4);
      checkOutput("cfg_idle", 32'(sched_idle), 1);

      $display("[TB] single byte 0xA5 from req0");
      clearCounts();
      applyStimulus(0, 8'hA5, 1'b1, 1'b1);
      tick();
      n = 0;
      while (uart_transmit && n < 20) begin
         tick();
         n++;
      end
      checkOutput("t1_latency", n, 2);
      checkOutput("t1_grant", 32'(grant), 32'h1);
      waitIdle("t1_done");
      checkOutput("t1_line", 32'(last_line), 32'({1'b1, 8'hA5, 1'b0}));
      checkOutput("t1_ready0", ready_cnt[0], 1);
      checkOutput("t1_grant_idle", 32'(grant), 0);
      checkOutput("t1_startlen", start_len, 4);

      $display("[TB] 3-byte packet on req1 while req2 waits");
      clearCounts();
      applyStimulus(1, 8'h11, 1'b0, 1'b1);
      applyStimulus(1, 8'h22, 1'b0, 1'b1);
      applyStimulus(1, 8'h33, 1'b1, 1'b1);
      applyStimulus(2, 8'h44, 1'b1, 1'b1);
      tick();
      waitIdle("t2_done");
      checkOutput("t2_ready1", ready_cnt[1], 3);
      checkOutput("t2_ready2", ready_cnt[2], 1);
      applyStimulus(3, 8'h5C, 1'b1, 1'b1);
      tick();
      waitIdle("t2b_done");

      $display("[TB] all four requesters, two rounds");
      clearCounts();
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < NR; i++) begin
            b = 8'h80 + 8'(r * 16 + i);
            applyStimulus(i, b, 1'b1, 1'b1);
         end
      end
      tick();
      waitIdle("t3_done");
      for (int i = 0; i < NR; i++) checkOutput("t3_ready", ready_cnt[i], 2);

      $display("[TB] prescaler update during a frame");
      applyStimulus(0, 8'h5A, 1'b1, 1'b1);
      tick();
      n = 0;
      while (!active && n < 100) begin
         tick();
         n++;
      end
      checkOutput("t4_start", 32'(active), 1);
      repeat (3) tick();
      cfg_prescaler = 16'h0010;
      cfg_update    = 1'b1;
      tick();
      cfg_update = 1'b0;
      checkOutput("t4_hold", 32'(prescaler), 4);
      checkOutput("t4_not_idle", 32'(sched_idle), 0);
      n = 0;
      while (grant != '0 && n < 500) begin
         tick();
         n++;
      end
      checkOutput("t4_end", 32'(grant), 0);
      checkOutput("t4_psc_before", 32'(prescaler), 4);
      tick();
      checkOutput("t4_psc_after", 32'(prescaler), 16);
      applyStimulus(1, 8'h3C, 1'b1, 1'b1);
      tick();
      waitIdle("t4_done");
      checkOutput("t4_startlen", start_len, 16);

      $display("[TB] reset during WAIT_DONE");
      clearCounts();
      applyStimulus(2, 8'h77, 1'b1, 1'b1);
      tick();
      n = 0;
      while (ready_cnt[2] == 0 && n < 500) begin
         tick();
         n++;
      end
      checkOutput("t5_taken", ready_cnt[2], 1);
      repeat (2) tick();
      reset = 1'b0;
      tick();
      checkOutput("t5_grant", 32'(grant), 0);
      checkOutput("t5_tx", 32'(uart_transmit), 1);
      checkOutput("t5_psc", 32'(prescaler), 5208);
      checkOutput("t5_ready", 32'(req_ready), 0);
      reset         = 1'b1;
      cfg_prescaler = 16'h0010;
      cfg_update    = 1'b1;
      tick();
      cfg_update = 1'b0;
      tick();
      checkOutput("t5_psc_restore", 32'(prescaler), 16);
      n = 0;
      while (active && n < 500) begin
         tick();
         n++;
      end
      checkOutput("t5_inflight_done", 32'(active), 0);
      applyStimulus(3, 8'h99, 1'b1, 1'b1);
      tick();
      waitIdle("t5_done");
      checkOutput("t5_ready3", ready_cnt[3], 1);

`ifdef UART_TX_SCHED_TIMEOUT_EN
      $display("[TB] watchdog with transmitter never busy");
      clearCounts();
      force_idle = 1'b1;
      applyStimulus(0, 8'hE1, 1'b1, 1'b0);
      applyStimulus(1, 8'hE2, 1'b1, 1'b0);
      tick();
      n = 0;
      while (uart_transmit && n < 20) begin
         tick();
         n++;
      end
      checkOutput("t6_load", 32'(uart_transmit), 0);
      n = 0;
      while (!sched_timeout && n < 300) begin
         tick();
         n++;
      end
      checkOutput("t6_timeout_cycles", n, 100);
      checkOutput("t6_no_ready", ready_cnt[0], 0);
      checkOutput("t6_grant_clr", 32'(grant), 0);
      checkOutput("t6_tx_high", 32'(uart_transmit), 1);
      tick();
      checkOutput("t6_pulse", 32'(sched_timeout), 0);
      checkOutput("t6_next_grant", 32'(grant), 32'h2);
      txq[0].delete();
      txq[1].delete();
      reset = 1'b0;
      repeat (2) tick();
      reset      = 1'b1;
      force_idle = 1'b0;
      tick();
`endif

      checkOutput("sb_drain", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
